bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arb_pkg.sv | 11 +
 rtl/bus_arbiter_rr_pick.sv | 28 ++
 rtl/bus_arbiter.sv | 84 ++++++++
 tb/tb_bus_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared constants and state encoding for the 4-way round-robin bus arbiter.
package bus_arb_pkg;
  localparam int unsigned NUM_REQ          = 4;
  localparam int unsigned IDX_W            = 2;
  localparam int unsigned HOLD_MAX_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit after 'last', wrapping,
// with 'last' itself considered at lowest priority.
module rr_pick
  import bus_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset to the nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = last;
    cand  = last;
    for (int k = NUM_REQ; k > 0; k--) begin
      cand = last + IDX_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter driving a 4:1 bus selector (sel/enable/grant, all registered).
// Optional per-owner hold limit compiled in with `define BUS_ARB_HOLD_LIMIT_EN.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [IDX_W-1:0]   sel,
  output logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

`ifdef BUS_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_LIMIT_EN = 1'b1;
`else
  localparam bit HOLD_LIMIT_EN = 1'b0;
`endif

  state_e             state;
  logic [IDX_W-1:0]   last;
  logic [CNT_W-1:0]   hold_cnt;

  logic               found_c;
  logic [IDX_W-1:0]   pick_c;
  logic               hold_expired_c;
  logic               take_c;

  rr_pick u_rr_pick (
    .req   (req),
    .last  (last),
    .found (found_c),
    .idx   (pick_c)
  );

  // A new owner is taken from idle, on owner release, or on hold expiry when someone else waits.
  always_comb begin
    hold_expired_c = HOLD_LIMIT_EN && (hold_cnt == CNT_LAST);
    take_c         = 1'b0;
    if (found_c) begin
      if (state == IDLE) begin
        take_c = 1'b1;
      end else if (!req[sel]) begin
        take_c = 1'b1;
      end else if (hold_expired_c && (pick_c != sel)) begin
        take_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= '0;
      enable   <= 1'b0;
      grant    <= '0;
      last     <= IDX_W'(NUM_REQ - 1);
      hold_cnt <= '0;
    end else if (take_c) begin
      state    <= GRANT;
      sel      <= pick_c;
      enable   <= 1'b1;
      grant    <= NUM_REQ'(1) << pick_c;
      last     <= pick_c;
      hold_cnt <= '0;
    end else if (state == GRANT) begin
      if (!req[sel]) begin
        state  <= IDLE;
        enable <= 1'b0;
        grant  <= '0;
      end else if (hold_expired_c) begin
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: per-cycle reference model plus directed scenarios.
module tb_bus_arbiter;

  localparam int HM = 4;
`ifdef BUS_ARB_HOLD_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [1:0] sel;
  logic       enable;
  logic [3:0] grant;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  // Reference model state: owner -1 means nobody holds the bus.
  int m_owner = -1;
  int m_last  = 3;
  int m_sel   = 0;
  int m_cnt   = 0;
  int wait_cnt [4] = '{0, 0, 0, 0};

  bus_arbiter #(.HOLD_MAX(HM)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .sel    (sel),
    .enable (enable),
    .grant  (grant)
  );

  always #5 clk = ~clk;

  function automatic int rr_next(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (from + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on every edge, then compare DUT outputs shortly after.
  always @(posedge clk) begin
    int p;
    int exp_grant;
    if (reset) begin
      m_owner = -1; m_sel = 0; m_last = 3; m_cnt = 0;
    end else begin
      p = rr_next(req, m_last);
      if (m_owner < 0) begin
        if (p >= 0) begin m_owner = p; m_sel = p; m_last = p; m_cnt = 0; end
      end else if (!req[m_owner]) begin
        if (p >= 0) begin m_owner = p; m_sel = p; m_last = p; m_cnt = 0; end
        else m_owner = -1;
      end else if (LIMIT && m_cnt == HM - 1) begin
        if (p != m_owner) begin m_owner = p; m_sel = p; m_last = p; m_cnt = 0; end
        else m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    #1;
    if (checking) begin
      exp_grant = (m_owner >= 0) ? (1 << m_owner) : 0;
      check("model_enable", int'(enable), (m_owner >= 0) ? 1 : 0);
      check("model_grant", int'(grant), exp_grant);
      check("model_sel", int'(sel), m_sel);
      if (enable) check("grant_matches_sel", int'(grant), 1 << sel);
      else        check("grant_zero_when_idle", int'(grant), 0);
      for (int i = 0; i < 4; i++) begin
        if (req[i] && !reset && !grant[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (LIMIT && wait_cnt[i] > 3 * HM) begin
          n_tests++;
          n_fail++;
          $display("FAIL starvation req%0d: waited %0d cycles, limit %0d", i, wait_cnt[i], 3 * HM);
          wait_cnt[i] = 0;
        end
      end
    end
  end

  task automatic step(input logic [3:0] r, input logic rst);
    @(negedge clk);
    req   = r;
    reset = rst;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int exp_owner;

    // Reset state, with requests present to show they are ignored.
    step(4'b1111, 1'b1);
    checking = 1'b1;
    check("reset_enable", int'(enable), 0);
    check("reset_grant", int'(grant), 0);
    check("reset_sel", int'(sel), 0);

    // All four requesting: owner 0 first, then rotation every HM cycles with the limit.
    for (int k = 0; k < 20; k++) begin
      step(4'b1111, 1'b0);
      exp_owner = LIMIT ? (k / 4) % 4 : 0;
      check("rotate_grant", int'(grant), 1 << exp_owner);
      check("rotate_sel", int'(sel), exp_owner);
    end

    // Single requester for 3 cycles, then release: sel stays at 2.
    step(4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(4'b0100, 1'b0);
      check("req2_grant", int'(grant), 4'b0100);
    end
    step(4'b0000, 1'b0);
    check("release_enable", int'(enable), 0);
    check("release_grant", int'(grant), 0);
    check("release_sel", int'(sel), 2);

    // Owner 1 drops while 0 and 3 wait: handover to 3 with no gap.
    step(4'b0010, 1'b0);
    check("own1_grant", int'(grant), 4'b0010);
    step(4'b1001, 1'b0);
    check("handover_grant", int'(grant), 4'b1000);
    check("handover_sel", int'(sel), 3);
    check("handover_enable", int'(enable), 1);

    // Lone requester is never preempted; without the limit owner 0 keeps 0011 forever.
    step(4'b0000, 1'b1);
    for (int k = 0; k < 10; k++) step(4'b0010, 1'b0);
    check("lone_hold_grant", int'(grant), 4'b0010);
    if (!LIMIT) begin
      step(4'b0000, 1'b1);
      for (int k = 0; k < 10; k++) step(4'b0011, 1'b0);
      check("nolimit_hold_grant", int'(grant), 4'b0001);
    end

    // Reset pulse during grant to 2, then 1100 arbitrates with 0 at top priority.
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    check("pre_reset_grant", int'(grant), 4'b0100);
    step(4'b0100, 1'b1);
    check("pulse_enable", int'(enable), 0);
    check("pulse_sel", int'(sel), 0);
    step(4'b1100, 1'b0);
    check("post_reset_grant", int'(grant), 4'b0100);
    check("post_reset_sel", int'(sel), 2);

    // Random traffic with persistent requests and rare resets.
    begin
      logic [3:0] r;
      r = 4'b0000;
      for (int k = 0; k < 10000; k++) begin
        r = r ^ 4'($urandom & $urandom);
        step(r, ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
